// File: rtl/transceiver_arbiter.sv
// Round-robin owner arbitration for one shared bidirectional transceiver, with a dead turnaround window on every dir change.
// Optional macro XCVR_ARB_HOLD_LIMIT_EN: preempt an owner after MAX_HOLD grant cycles when the other side is waiting.
module transceiver_arbiter #(
    parameter int TURN_CYCLES = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b,
    output logic dir,
    output logic g,
    output logic busy
);
    typedef enum logic [1:0] {IDLE, TURN, GNT_A, GNT_B} state_t;

    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    if (TURN_CYCLES < 1) begin : g_bad_turn_cycles
        $error("TURN_CYCLES must be >= 1");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("MAX_HOLD must be >= 1");
    end

    state_t          state_reg, state_next;
    logic            dir_reg, dir_next;
    logic            last_a_reg, last_a_next;   // 1 = A owned last, 0 = B
    logic [TW-1:0]   turn_cnt_reg, turn_cnt_next;
    logic            g_reg, g_next;
    logic            grant_a_reg, grant_a_next;
    logic            grant_b_reg, grant_b_next;
    logic            busy_reg, busy_next;
    logic            win_a;
    logic            hold_full;

    // On a contest the side that did not own the link last wins
    assign win_a = req_a && (!req_b || !last_a_reg);

`ifdef XCVR_ARB_HOLD_LIMIT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;

    assign hold_full = (hold_cnt_reg == HW'(MAX_HOLD));

    // Counts grant cycles including the first; saturates so a long owner stays preemptible
    always_comb begin
        hold_cnt_next = '0;
        if (state_next == GNT_A || state_next == GNT_B) begin
            if (state_reg == state_next)
                hold_cnt_next = hold_full ? hold_cnt_reg : hold_cnt_reg + HW'(1);
            else
                hold_cnt_next = HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) hold_cnt_reg <= '0;
        else        hold_cnt_reg <= hold_cnt_next;
    end
`else
    assign hold_full = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            dir_reg      <= 1'b0;
            last_a_reg   <= 1'b0;
            turn_cnt_reg <= '0;
            g_reg        <= 1'b1;
            grant_a_reg  <= 1'b0;
            grant_b_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dir_reg      <= dir_next;
            last_a_reg   <= last_a_next;
            turn_cnt_reg <= turn_cnt_next;
            g_reg        <= g_next;
            grant_a_reg  <= grant_a_next;
            grant_b_reg  <= grant_b_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        dir_next      = dir_reg;
        last_a_next   = last_a_reg;
        turn_cnt_next = turn_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_a || req_b) begin
                    if (win_a == dir_reg) begin
                        state_next = win_a ? GNT_A : GNT_B;
                    end else begin
                        state_next    = TURN;
                        dir_next      = win_a;
                        turn_cnt_next = TW'(TURN_CYCLES - 1);
                    end
                end
            end
            TURN: begin
                // dir already points at the target side
                if (turn_cnt_reg == '0) begin
                    if (dir_reg) state_next = req_a ? GNT_A : IDLE;
                    else         state_next = req_b ? GNT_B : IDLE;
                end else begin
                    turn_cnt_next = turn_cnt_reg - TW'(1);
                end
            end
            GNT_A: begin
                if (!req_a || (hold_full && req_b)) begin
                    last_a_next = 1'b1;
                    if (req_b) begin
                        state_next    = TURN;
                        dir_next      = 1'b0;
                        turn_cnt_next = TW'(TURN_CYCLES - 1);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GNT_B: begin
                if (!req_b || (hold_full && req_a)) begin
                    last_a_next = 1'b0;
                    if (req_a) begin
                        state_next    = TURN;
                        dir_next      = 1'b1;
                        turn_cnt_next = TW'(TURN_CYCLES - 1);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land in registers on the same edge
    always_comb begin
        grant_a_next = (state_next == GNT_A);
        grant_b_next = (state_next == GNT_B);
        g_next       = !(grant_a_next || grant_b_next);
        busy_next    = (state_next != IDLE);
    end

    assign g       = g_reg;
    assign dir     = dir_reg;
    assign grant_a = grant_a_reg;
    assign grant_b = grant_b_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_transceiver_arbiter.sv
// Self-checking bench for transceiver_arbiter: directed scenarios plus random traffic against a phase-level model.
module tb_transceiver_arbiter;
    localparam int TURN_CYCLES = 2;
    localparam int MAX_HOLD    = 4;
`ifdef XCVR_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_a = 1'b0;
    logic req_b = 1'b0;
    logic grant_a, grant_b, dir, g, busy;
    logic [4:0] obs;

    int total = 0;
    int bad = 0;

    // Model: owner 0=none 1=A 2=B; turn = turnaround cycles still to spend
    int m_owner = 0;
    int m_turn  = 0;
    int m_dir   = 0;
    int m_last  = 2;
    int m_hold  = 0;

    transceiver_arbiter #(.TURN_CYCLES(TURN_CYCLES), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .grant_a(grant_a), .grant_b(grant_b), .dir(dir), .g(g), .busy(busy)
    );

    always #5 clk = ~clk;
    assign obs = {g, dir, grant_a, grant_b, busy};

    task automatic model_step();
        int rq [3];
        int other, win;
        bit preempt;
        rq[0] = 0; rq[1] = int'(req_a); rq[2] = int'(req_b);
        if (!rst_n) begin
            m_owner = 0; m_turn = 0; m_dir = 0; m_last = 2; m_hold = 0;
        end else if (m_turn > 0) begin
            m_turn--;
            if (m_turn == 0 && rq[m_dir ? 1 : 2] != 0) begin
                m_owner = m_dir ? 1 : 2;
                m_hold = 1;
            end
        end else if (m_owner != 0) begin
            other = 3 - m_owner;
            preempt = HOLD_EN && m_hold >= MAX_HOLD && rq[other] != 0;
            if (rq[m_owner] == 0 || preempt) begin
                m_last = m_owner; m_owner = 0; m_hold = 0;
                if (rq[other] != 0) begin
                    m_dir = (other == 1) ? 1 : 0;
                    m_turn = TURN_CYCLES;
                end
            end else if (m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end else if (req_a || req_b) begin
            win = (req_a && req_b) ? 3 - m_last : (req_a ? 1 : 2);
            if ((win == 1) == (m_dir == 1)) begin
                m_owner = win; m_hold = 1;
            end else begin
                m_dir = (win == 1) ? 1 : 0;
                m_turn = TURN_CYCLES;
            end
        end
    endtask

    function automatic logic [4:0] model_out();
        logic [4:0] v;
        v[4] = (m_owner == 0);
        v[3] = (m_dir != 0);
        v[2] = (m_owner == 1);
        v[1] = (m_owner == 2);
        v[0] = (m_owner != 0) || (m_turn > 0);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Expected vectors below are {g, dir, grant_a, grant_b, busy}
    task automatic test_reset();
        rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (obs !== 5'b10000) begin
                bad++;
                $display("FAIL reset cyc%0d: got %b want 10000", i, obs);
            end else $display("reset cyc%0d ok %b", i, obs);
        end
        rst_n = 1'b1; req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic test_same_dir();
        logic [4:0] exp_v [3] = '{5'b00011, 5'b00011, 5'b10000};
        do_reset();
        req_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) req_b = 1'b0;
            tick();
            total++;
            if (obs !== exp_v[i]) begin
                bad++;
                $display("FAIL same_dir edge%0d: got %b want %b", i + 1, obs, exp_v[i]);
            end else $display("same_dir edge%0d ok %b", i + 1, obs);
        end
    endtask

    task automatic test_turn();
        logic [4:0] exp_v [4] = '{5'b11001, 5'b11001, 5'b01101, 5'b11000};
        do_reset();
        req_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) req_a = 1'b0;
            tick();
            total++;
            if (obs !== exp_v[i]) begin
                bad++;
                $display("FAIL turn edge%0d: got %b want %b", i + 1, obs, exp_v[i]);
            end else $display("turn edge%0d ok %b", i + 1, obs);
        end
    endtask

    task automatic test_contest();
        logic [4:0] exp_v [8] = '{5'b11001, 5'b11001, 5'b01101, 5'b01101,
                                  5'b10001, 5'b10001, 5'b00011, 5'b10000};
        do_reset();
        req_a = 1'b1; req_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) req_a = 1'b0;
            if (i == 7) req_b = 1'b0;
            tick();
            total++;
            if (obs !== exp_v[i]) begin
                bad++;
                $display("FAIL contest edge%0d: got %b want %b", i + 1, obs, exp_v[i]);
            end else $display("contest edge%0d ok %b", i + 1, obs);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_a = 1'b1;
        repeat (3) tick();
        total++;
        if (obs !== 5'b01101) begin
            bad++;
            $display("FAIL reset_mid pre: got %b want 01101", obs);
        end else $display("reset_mid pre ok %b", obs);
        rst_n = 1'b0;
        tick();
        total++;
        if (obs !== 5'b10000) begin
            bad++;
            $display("FAIL reset_mid post: got %b want 10000", obs);
        end else $display("reset_mid post ok %b", obs);
        rst_n = 1'b1; req_a = 1'b0;
    endtask

`ifdef XCVR_ARB_HOLD_LIMIT_EN
    task automatic test_hold();
        logic [4:0] exp_v [6] = '{5'b01101, 5'b01101, 5'b01101, 5'b10001, 5'b10001, 5'b00011};
        do_reset();
        req_a = 1'b1;
        repeat (3) tick();
        req_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (obs !== exp_v[i]) begin
                bad++;
                $display("FAIL hold step%0d: got %b want %b", i, obs, exp_v[i]);
            end else $display("hold step%0d ok %b", i, obs);
        end
        req_a = 1'b0; req_b = 1'b0;
    endtask
`endif

    // Agents raise a request, keep it until granted, then release after a while; rare early drops and resets
    task automatic test_random();
        logic [4:0] exp_v;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if (!req_a) req_a = ($urandom_range(0, 3) == 0);
            else if (m_owner == 1) req_a = ($urandom_range(0, 5) != 0);
            else req_a = ($urandom_range(0, 24) != 0);
            if (!req_b) req_b = ($urandom_range(0, 3) == 0);
            else if (m_owner == 2) req_b = ($urandom_range(0, 5) != 0);
            else req_b = ($urandom_range(0, 24) != 0);
            tick();
            exp_v = model_out();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL random cyc%0d rst_n=%b req=%b%b: got %b want %b",
                         i, rst_n, req_a, req_b, obs, exp_v);
            end else $display("random cyc%0d req=%b%b ok %b", i, req_a, req_b, obs);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_same_dir();
        test_turn();
        test_contest();
        test_reset_mid();
`ifdef XCVR_ARB_HOLD_LIMIT_EN
        test_hold();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
